// File: rtl/pipeline_hazard_control.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_control
//   Hazard/control unit for a 5-stage in-order pipeline. Detects load-use
//   hazards, handles taken branches (two-cycle flush to cover the wrong-path
//   fetch out of synchronous instruction RAM) and multi-cycle EX operations
//   (stall until done, with a watchdog timeout).
//
//   Optional build macro: PIPE_HAZARD_PERF_EN enables the saturating stall and
//   flush performance counters; without it the counter outputs are tied to 0.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   ID_Rs1/ID_Rs2, ID_UsesRs1/2      sources of the instruction in ID
//   EX_Rd, EX_MemRead                destination / load flag of the EX instr
//   EX_BranchTaken                   EX instruction redirects the PC
//   EX_McStart, EX_McDone            multi-cycle op active / result valid
//   Pc_Stall, IF_ID_Stall, ID_EX_Stall   hold the PC / pipeline registers
//   IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush  bubble into that register
//   Ctrl_State                       FSM state (RUN=0, REDIRECT=1, MC_WAIT=2)
//   Mc_Timeout                       one-cycle multi-cycle timeout pulse
//   Stall_Count, Flush_Count         performance counters
// -----------------------------------------------------------------------------
module pipeline_hazard_control #(
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           ID_Rs1,
    input  logic [4:0]           ID_Rs2,
    input  logic                 ID_UsesRs1,
    input  logic                 ID_UsesRs2,
    input  logic [4:0]           EX_Rd,
    input  logic                 EX_MemRead,
    input  logic                 EX_BranchTaken,
    input  logic                 EX_McStart,
    input  logic                 EX_McDone,
    output logic                 Pc_Stall,
    output logic                 IF_ID_Stall,
    output logic                 ID_EX_Stall,
    output logic                 IF_ID_Flush,
    output logic                 ID_EX_Flush,
    output logic                 EX_MEM_Flush,
    output logic [1:0]           Ctrl_State,
    output logic                 Mc_Timeout,
    output logic [CNT_WIDTH-1:0] Stall_Count,
    output logic [CNT_WIDTH-1:0] Flush_Count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        MC_WAIT  = 2'd2
    } state_e;

    // Wait counter holds (MC_WAIT cycles elapsed - 1); the last allowed cycle
    // is the one where it equals MC_TIMEOUT-1.
    localparam logic [15:0] WAIT_LAST = 16'(MC_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic        load_use;

    logic pc_stall, ifid_stall, idex_stall;
    logic ifid_flush, idex_flush, exmem_flush, mc_to;

    assign load_use = EX_MemRead && (EX_Rd != 5'd0) &&
                      ((ID_UsesRs1 && (ID_Rs1 == EX_Rd)) ||
                       (ID_UsesRs2 && (ID_Rs2 == EX_Rd)));

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mc_to       = 1'b0;
        case (state_q)
            RUN: begin
                if (EX_BranchTaken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    state_d    = REDIRECT;
                end else if (EX_McStart) begin
                    // A multi-cycle op finishing in its first cycle needs no stall.
                    if (!EX_McDone) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_stall  = 1'b1;
                        exmem_flush = 1'b1;
                        wait_d      = '0;
                        state_d     = MC_WAIT;
                    end
                end else if (load_use) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            REDIRECT: begin
                // Second flush cycle squashes the wrong-path fetch already in flight.
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                state_d    = RUN;
            end
            MC_WAIT: begin
                if (EX_McDone) begin
                    state_d = RUN;
                end else if (wait_q == WAIT_LAST) begin
                    // Give up: release the pipe but keep EX/MEM bubbled.
                    exmem_flush = 1'b1;
                    mc_to       = 1'b1;
                    state_d     = RUN;
                end else begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_flush = 1'b1;
                    wait_d      = wait_q + 16'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Outputs are quiet while reset is held, whatever the stale state says.
    assign Pc_Stall     = pc_stall    & ~reset;
    assign IF_ID_Stall  = ifid_stall  & ~reset;
    assign ID_EX_Stall  = idex_stall  & ~reset;
    assign IF_ID_Flush  = ifid_flush  & ~reset;
    assign ID_EX_Flush  = idex_flush  & ~reset;
    assign EX_MEM_Flush = exmem_flush & ~reset;
    assign Mc_Timeout   = mc_to       & ~reset;
    assign Ctrl_State   = state_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (Pc_Stall && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if ((IF_ID_Flush || ID_EX_Flush) && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign Stall_Count = stall_cnt_q;
    assign Flush_Count = flush_cnt_q;
`else
    assign Stall_Count = '0;
    assign Flush_Count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_control.sv
module tb_pipeline_hazard_control;

  localparam int unsigned TO = 8;
  localparam int unsigned CW = 32;
`ifdef PIPE_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // expected output vector {PS,IS,ES,IF,EF,MF,TO,state[1:0]}
  localparam logic [8:0] B_PS = 9'h100, B_IS = 9'h080, B_ES = 9'h040;
  localparam logic [8:0] B_IF = 9'h020, B_EF = 9'h010, B_MF = 9'h008, B_TO = 9'h004;
  localparam logic [8:0] S_RUN = 9'd0, S_RED = 9'd1, S_MC = 9'd2;
  localparam logic [8:0] LU  = B_PS | B_IS | B_EF;
  localparam logic [8:0] BR  = B_IF | B_EF;
  localparam logic [8:0] MCS = B_PS | B_IS | B_ES | B_MF;

  logic clk = 1'b0, reset;
  logic [4:0] ID_Rs1, ID_Rs2, EX_Rd;
  logic ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_BranchTaken, EX_McStart, EX_McDone;
  logic Pc_Stall, IF_ID_Stall, ID_EX_Stall, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Mc_Timeout;
  logic [1:0] Ctrl_State;
  logic [CW-1:0] Stall_Count, Flush_Count;

  int n_chk = 0, n_err = 0;
  int sc_exp = 0, fc_exp = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_control #(.MC_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
    .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead), .EX_BranchTaken(EX_BranchTaken),
    .EX_McStart(EX_McStart), .EX_McDone(EX_McDone),
    .Pc_Stall(Pc_Stall), .IF_ID_Stall(IF_ID_Stall), .ID_EX_Stall(ID_EX_Stall),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Flush(EX_MEM_Flush),
    .Ctrl_State(Ctrl_State), .Mc_Timeout(Mc_Timeout),
    .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; ID_Rs1 = '0; ID_Rs2 = '0; ID_UsesRs1 = 1'b0; ID_UsesRs2 = 1'b0;
    EX_Rd = '0; EX_MemRead = 1'b0; EX_BranchTaken = 1'b0; EX_McStart = 1'b0; EX_McDone = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    EX_MemRead = 1'b1; EX_Rd = rd; ID_Rs1 = rd; ID_UsesRs1 = 1'b1;
  endtask

  // One clock: push expectation, compare mid-cycle, advance past the edge.
  task automatic cyc(input string tag, input logic [8:0] exp);
    logic [8:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, {55'd0, Pc_Stall, IF_ID_Stall, ID_EX_Stall, IF_ID_Flush, ID_EX_Flush,
                EX_MEM_Flush, Mc_Timeout, Ctrl_State}, {55'd0, e});
    if (reset) begin
      sc_exp = 0; fc_exp = 0;
    end else if (PERF) begin
      if (e[8]) sc_exp++;
      if (e[5] || e[4]) fc_exp++;
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_cnt(input string tag);
    check({tag, "_stall_cnt"}, 64'(Stall_Count), 64'(sc_exp));
    check({tag, "_flush_cnt"}, 64'(Flush_Count), 64'(fc_exp));
  endtask

  initial begin
    idle(); reset = 1'b1;
    @(posedge clk); #1;
    cyc("reset_hold", S_RUN);
    chk_cnt("reset");
    idle();
    cyc("idle", S_RUN);

    // load-use variants
    set_lu(5'd5);                       cyc("lu_rs1", LU);
    idle();                             cyc("lu_release", S_RUN);
    EX_MemRead = 1; EX_Rd = 7; ID_Rs2 = 7; ID_UsesRs2 = 1; cyc("lu_rs2", LU);
    idle(); EX_MemRead = 1; EX_Rd = 5; ID_Rs1 = 5;         cyc("lu_nouse", S_RUN);
    idle(); EX_Rd = 5; ID_Rs1 = 5; ID_UsesRs1 = 1;         cyc("lu_noload", S_RUN);
    idle(); EX_MemRead = 1; EX_Rd = 0; ID_Rs2 = 0; ID_UsesRs2 = 1; cyc("lu_x0", S_RUN);
    idle(); EX_MemRead = 1; EX_Rd = 5; ID_Rs1 = 6; ID_UsesRs1 = 1; cyc("lu_nomatch", S_RUN);

    // branch beats load-use; REDIRECT ignores its inputs
    idle(); set_lu(5'd3); EX_BranchTaken = 1; cyc("br_lu", BR | S_RUN);
    EX_McStart = 1;                           cyc("redirect", BR | S_RED);
    idle();                                   cyc("br_back", S_RUN);
    chk_cnt("after_br");

    // multi-cycle op, done 4 cycles after start
    EX_McStart = 1;                           cyc("mc_start", MCS | S_RUN);
    EX_BranchTaken = 1;                       cyc("mc_w1_br_ign", MCS | S_MC);
    EX_BranchTaken = 0; set_lu(5'd9);         cyc("mc_w2_lu_ign", MCS | S_MC);
    idle(); EX_McStart = 1;                   cyc("mc_w3", MCS | S_MC);
    EX_McDone = 1;                            cyc("mc_done", S_MC);
    idle();                                   cyc("mc_back", S_RUN);
    chk_cnt("after_mc");

    // immediate completion; branch over mc start; mc start over load-use
    EX_McStart = 1; EX_McDone = 1;            cyc("mc_imm", S_RUN);
    idle(); EX_McStart = 1; EX_BranchTaken = 1; cyc("br_over_mc", BR | S_RUN);
    idle();                                   cyc("br_over_mc_red", BR | S_RED);
    set_lu(5'd4); EX_McStart = 1;             cyc("mc_over_lu", MCS | S_RUN);
    idle(); EX_McDone = 1;                    cyc("mc_over_lu_done", S_MC);
    idle();                                   cyc("mc_over_lu_back", S_RUN);

    // timeout
    EX_McStart = 1;                           cyc("to_start", MCS | S_RUN);
    idle();
    for (int i = 1; i < TO; i++)              cyc($sformatf("to_w%0d", i), MCS | S_MC);
    cyc("to_pulse", B_MF | B_TO | S_MC);
    cyc("to_back", S_RUN);

    // done wins on the timeout cycle
    EX_McStart = 1;                           cyc("tod_start", MCS | S_RUN);
    idle();
    for (int i = 1; i < TO; i++)              cyc($sformatf("tod_w%0d", i), MCS | S_MC);
    EX_McDone = 1;                            cyc("tod_done", S_MC);
    idle();                                   cyc("tod_back", S_RUN);
    chk_cnt("after_to");

    // reset in the third MC_WAIT cycle
    EX_McStart = 1;                           cyc("rmc_start", MCS | S_RUN);
    idle();                                   cyc("rmc_w1", MCS | S_MC);
                                              cyc("rmc_w2", MCS | S_MC);
    reset = 1;                                cyc("rmc_reset", S_MC);
    reset = 0;                                cyc("rmc_after", S_RUN);
    chk_cnt("after_rst");

    // random load-use patterns from RUN
    for (int i = 0; i < 40; i++) begin
      logic hz;
      idle();
      EX_MemRead = 1'($urandom_range(0, 1));
      EX_Rd  = 5'($urandom_range(0, 3));
      ID_Rs1 = 5'($urandom_range(0, 3));
      ID_Rs2 = 5'($urandom_range(0, 3));
      ID_UsesRs1 = 1'($urandom_range(0, 1));
      ID_UsesRs2 = 1'($urandom_range(0, 1));
      hz = EX_MemRead && EX_Rd != 0 &&
           ((ID_UsesRs1 && ID_Rs1 == EX_Rd) || (ID_UsesRs2 && ID_Rs2 == EX_Rd));
      cyc($sformatf("rnd%0d", i), hz ? LU : S_RUN);
    end
    idle();
    cyc("final_idle", S_RUN);
    chk_cnt("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_control.md
PIPELINE_HAZARD_CONTROL -- requirements
Module: pipeline_hazard_control

Interface
REQ-001 Parameter MC_TIMEOUT, 64: maximum multi-cycle EX wait, in cycles; SHALL be 2..65535.
REQ-002 Parameter CNT_WIDTH, 32: width of the performance counters.
REQ-003 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Ports ID_Rs1, ID_Rs2  in  5 each  source registers of the instruction in ID.
REQ-006 Ports ID_UsesRs1, ID_UsesRs2  in  1 each  the ID instruction reads Rs1/Rs2.
REQ-007 Ports EX_Rd  in  5, and EX_MemRead  in  1  destination and load flag of the instruction in EX.
REQ-008 Port EX_BranchTaken  in  1  the EX instruction redirects the PC this cycle.
REQ-009 Ports EX_McStart, EX_McDone  in  1 each  a multi-cycle EX op is active / its result is valid this cycle.
REQ-010 Ports Pc_Stall, IF_ID_Stall, ID_EX_Stall  out  1 each  hold the PC / IF_ID register / ID_EX register.
REQ-011 Ports IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush  out  1 each  insert a bubble into that register.
REQ-012 Ports Ctrl_State  out  2  current FSM state; Mc_Timeout  out  1  one-cycle timeout pulse.
REQ-013 Ports Stall_Count, Flush_Count  out  CNT_WIDTH each  performance counters.

Function
REQ-014 FSM states SHALL be RUN=0, REDIRECT=1, MC_WAIT=2; encoding 3 SHALL be unreachable and SHALL return to RUN on the next edge.
REQ-015 Stall and flush outputs SHALL be combinational from the current state and the current inputs, so they act at the same clock edge.
REQ-016 Load-use hazard SHALL be defined as EX_MemRead=1, EX_Rd!=0, and ((ID_UsesRs1=1 and ID_Rs1=EX_Rd) or (ID_UsesRs2=1 and ID_Rs2=EX_Rd)).
REQ-017 In RUN, the priority SHALL be EX_BranchTaken > multi-cycle start > load-use.
REQ-018 RUN with EX_BranchTaken=1 SHALL drive IF_ID_Flush=1 and ID_EX_Flush=1 with no stalls, and SHALL move to REDIRECT.
REQ-019 REDIRECT SHALL drive IF_ID_Flush=1 and ID_EX_Flush=1 for exactly one cycle, to cover the synchronous-RAM wrong-path fetch, then return to RUN. All inputs SHALL be ignored in this state.
REQ-020 RUN with EX_McStart=1 and EX_McDone=0 SHALL drive Pc_Stall, IF_ID_Stall, ID_EX_Stall and EX_MEM_Flush to 1, clear the wait counter, and move to MC_WAIT.
REQ-021 RUN with EX_McStart=1 and EX_McDone=1 SHALL stall nothing and SHALL stay in RUN.
REQ-022 RUN load-use with no higher-priority event SHALL drive Pc_Stall=1, IF_ID_Stall=1 and ID_EX_Flush=1 for that cycle only, and SHALL stay in RUN.
REQ-023 MC_WAIT with EX_McDone=0 SHALL keep all three stalls and EX_MEM_Flush at 1, and SHALL increment the wait counter by 1 per cycle.
REQ-024 MC_WAIT with EX_McDone=1 SHALL deassert all stall and flush outputs that cycle and SHALL return to RUN.
REQ-025 In MC_WAIT, EX_BranchTaken and load-use SHALL be ignored.
REQ-026 A timeout SHALL occur when MC_WAIT has lasted MC_TIMEOUT cycles, counting the entry cycle, without EX_McDone. On that last cycle, Mc_Timeout=1, the stalls SHALL be released, EX_MEM_Flush SHALL stay 1, and the next state SHALL be RUN.
REQ-027 EX_McDone=1 on the timeout cycle SHALL take precedence: Mc_Timeout=0 and EX_MEM_Flush=0.
REQ-028 All outputs not asserted by REQ-018..REQ-027 SHALL be 0.

Reset
REQ-029 reset=1 at a clock edge SHALL set the state to RUN and clear the wait counter, Mc_Timeout and both performance counters, overriding any mid-operation state.
REQ-030 While reset=1, all stall and flush outputs SHALL be 0.

Configuration
REQ-031 With macro PIPE_HAZARD_PERF_EN defined, each cycle with Pc_Stall=1 SHALL increment Stall_Count, and each cycle with IF_ID_Flush=1 or ID_EX_Flush=1 SHALL increment Flush_Count. Both counters SHALL saturate at all-ones.
REQ-032 With PIPE_HAZARD_PERF_EN undefined, Stall_Count and Flush_Count SHALL be constant 0 and no counter flops SHALL be synthesized.

Verification
REQ-033 Load-use: EX_MemRead=1, EX_Rd=5, ID_Rs1=5, ID_UsesRs1=1 for one cycle -> Pc_Stall=IF_ID_Stall=ID_EX_Flush=1 for that one cycle; Ctrl_State stays 0.
REQ-034 Load to x0: EX_Rd=0, ID_Rs2=0, ID_UsesRs2=1, EX_MemRead=1 -> no stall, no flush.
REQ-035 Branch plus load-use in the same cycle -> IF_ID_Flush=ID_EX_Flush=1 and Pc_Stall=0; next cycle Ctrl_State=1 with both flushes still 1; the cycle after, Ctrl_State=0.
REQ-036 EX_McStart=1, with EX_McDone rising 4 cycles later -> stalls high for 4 cycles, low in the done cycle; Ctrl_State 0->2->0; Stall_Count=4 with PERF_EN defined.
REQ-037 MC_TIMEOUT=8, EX_McStart=1, EX_McDone never asserted -> Mc_Timeout pulses on the 8th cycle after entry; stalls drop that cycle; Ctrl_State returns to 0.
REQ-038 reset=1 during the 3rd MC_WAIT cycle -> next cycle Ctrl_State=0, all outputs 0, counters 0.
